// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the ID-stage hazard scoreboard.
// Holds the tracked-entry layout and the source-versus-entry conflict test.
package hazard_pkg;

    localparam int REG_W      = 5;
    localparam int SB_READY_W = 4;

    localparam logic [SB_READY_W-1:0] READY_ALU  = SB_READY_W'(0);
    localparam logic [SB_READY_W-1:0] READY_MFC0 = SB_READY_W'(2);
    localparam logic [SB_READY_W-1:0] READY_LOAD = SB_READY_W'(3);

    typedef struct packed {
        logic                  valid;
        logic [REG_W-1:0]      dst;
        logic [SB_READY_W-1:0] ready_at;
    } sb_entry_t;

    // An entry at `stage` is still pending while its result is not yet forwardable.
    function automatic logic src_match(input logic [REG_W-1:0] src, input logic rd,
                                       input sb_entry_t entry, input int unsigned stage);
        return rd && entry.valid && (entry.dst != '0) && (entry.dst == src)
               && (stage < 32'(entry.ready_at));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle: decoded operands in, stall decisions out.
interface hazard_scoreboard_if #(
    parameter int NUM_ISSUE  = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int READY_W    = 2
);
    logic [NUM_ISSUE*10-1:0]             id_src_reg;
    logic [NUM_ISSUE*2-1:0]              id_src_rd;
    logic [NUM_ISSUE*5-1:0]              id_dst_reg;
    logic [NUM_ISSUE-1:0]                id_dst_we;
    logic [NUM_ISSUE*READY_W-1:0]        id_ready_at;
    logic [NUM_ISSUE-1:0]                id_is_div;
    logic [NUM_ISSUE-1:0]                id_fire;
    logic                                pipe_advance;
    logic                                flush;
    logic [NUM_ISSUE-1:0]                id_stall;
    logic [NUM_ISSUE*(PIPE_DEPTH+1)-1:0] stall_src;
    logic                                lane1_dep;
    logic                                div_busy;

    modport master (
        output id_src_reg, id_src_rd, id_dst_reg, id_dst_we, id_ready_at,
               id_is_div, id_fire, pipe_advance, flush,
        input  id_stall, stall_src, lane1_dep, div_busy
    );

    modport slave (
        input  id_src_reg, id_src_rd, id_dst_reg, id_dst_we, id_ready_at,
               id_is_div, id_fire, pipe_advance, flush,
        output id_stall, stall_src, lane1_dep, div_busy
    );
endinterface

// File: rtl/hazard_scoreboard_div.sv
// Multi-cycle divider destination tracker: one outstanding divide, its
// countdown to forwardability, and the per-lane conflict it causes.
module sb_div_tracker
    import hazard_pkg::*;
#(
    parameter int NUM_ISSUE = 2,
    parameter int DIV_LAT   = 16
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 issue_i,
    input  logic [REG_W-1:0]                     issue_dst_i,
    input  logic [NUM_ISSUE-1:0][1:0][REG_W-1:0] src_reg_i,
    input  logic [NUM_ISSUE-1:0][1:0]            src_rd_i,
    input  logic [NUM_ISSUE-1:0]                 is_div_i,
    output logic [NUM_ISSUE-1:0]                 div_hit_o,
    output logic                                 div_busy_o
);
    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    logic             div_valid_q, div_valid_d;
    logic [REG_W-1:0] div_dst_q, div_dst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sb_entry_t        div_entry;

    always_comb begin
        div_valid_d = div_valid_q;
        div_dst_d   = div_dst_q;
        cnt_d       = cnt_q;
        if (issue_i) begin
            div_valid_d = 1'b1;
            div_dst_d   = issue_dst_i;
            cnt_d       = CNT_W'(DIV_LAT - 1);
        end else if (div_valid_q) begin
            if (cnt_q == '0) div_valid_d = 1'b0;
            else             cnt_d       = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_valid_q <= 1'b0;
            div_dst_q   <= '0;
            cnt_q       <= '0;
        end else begin
            div_valid_q <= div_valid_d;
            div_dst_q   <= div_dst_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outstanding divide looks like a stage-0 entry that is never yet forwardable.
    always_comb begin
        div_entry          = '0;
        div_entry.valid    = div_valid_q;
        div_entry.dst      = div_dst_q;
        div_entry.ready_at = SB_READY_W'(1);
        for (int l = 0; l < NUM_ISSUE; l++) begin
            div_hit_o[l] = (div_valid_q && is_div_i[l])
                         | src_match(src_reg_i[l][0], src_rd_i[l][0], div_entry, 0)
                         | src_match(src_reg_i[l][1], src_rd_i[l][1], div_entry, 0);
        end
    end

    assign div_busy_o = div_valid_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks not-yet-forwardable results in post-ID
// stages plus one divider, and stalls ID lanes that read them.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_ISSUE  = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int READY_W    = 2,
    parameter int DIV_LAT    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    hazard_scoreboard_if.slave bus
);
    localparam int CW = PIPE_DEPTH + 1;

    logic [NUM_ISSUE-1:0][1:0][REG_W-1:0]        src;
    logic [NUM_ISSUE-1:0][1:0]                   src_rd;
    sb_entry_t [PIPE_DEPTH-1:0][NUM_ISSUE-1:0]   stage_q, stage_d;
    logic [NUM_ISSUE-1:0][PIPE_DEPTH-1:0]        stage_hit;
    logic [NUM_ISSUE-1:0]                        div_hit;
    logic [NUM_ISSUE-1:0][CW-1:0]                cause, stall_src;
    logic [NUM_ISSUE-1:0]                        id_stall;
    logic                                        lane1_dep, dual_div, div_issue;
    logic [REG_W-1:0]                            div_dst;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        src    = '0;
        src_rd = '0;
        for (int l = 0; l < NUM_ISSUE; l++) begin
            for (int j = 0; j < 2; j++) begin
                src[l][j]    = bus.id_src_reg[l*10 + j*REG_W +: REG_W];
                src_rd[l][j] = bus.id_src_rd[l*2 + j];
            end
        end
    end

    always_comb begin
        stage_hit = '0;
        for (int l = 0; l < NUM_ISSUE; l++)
            for (int s = 0; s < PIPE_DEPTH; s++)
                for (int k = 0; k < NUM_ISSUE; k++)
                    for (int j = 0; j < 2; j++)
                        stage_hit[l][s] = stage_hit[l][s]
                                        | src_match(src[l][j], src_rd[l][j], stage_q[s][k], unsigned'(s));
    end

    if (NUM_ISSUE > 1) begin : g_bundle
        logic [REG_W-1:0] dst0;
        assign dst0      = bus.id_dst_reg[REG_W-1:0];
        assign lane1_dep = bus.id_dst_we[0] && (dst0 != '0)
                           && ((src_rd[1][0] && (src[1][0] == dst0))
                            || (src_rd[1][1] && (src[1][1] == dst0)));
        assign dual_div  = bus.id_is_div[0] & bus.id_is_div[1];
    end else begin : g_single
        assign lane1_dep = 1'b0;
        assign dual_div  = 1'b0;
    end

    // An intra-bundle dependency is reported as an EX hazard: lane 0 will be in EX next cycle.
    always_comb begin
        for (int l = 0; l < NUM_ISSUE; l++) begin
            cause[l] = {div_hit[l], stage_hit[l]};
            if (l == 1) begin
                cause[l][0]          = cause[l][0] | lane1_dep;
                cause[l][PIPE_DEPTH] = cause[l][PIPE_DEPTH] | dual_div;
            end
            stall_src[l] = cause[l] & (~cause[l] + CW'(1));
            id_stall[l]  = |cause[l];
        end
    end

    // Lane 0 is scanned last so it wins if both lanes fire a divide.
    always_comb begin
        div_issue = 1'b0;
        div_dst   = '0;
        for (int k = NUM_ISSUE - 1; k >= 0; k--) begin
            if (bus.id_fire[k] && bus.id_is_div[k]) begin
                div_issue = bus.pipe_advance && !bus.flush;
                div_dst   = bus.id_dst_reg[k*REG_W +: REG_W];
            end
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            for (int s = 0; s < PIPE_DEPTH; s++)
                for (int k = 0; k < NUM_ISSUE; k++)
                    stage_d[s][k].valid = 1'b0;
        end else if (bus.pipe_advance) begin
            for (int s = PIPE_DEPTH - 1; s > 0; s--)
                stage_d[s] = stage_q[s-1];
            for (int k = 0; k < NUM_ISSUE; k++) begin
                stage_d[0][k].valid    = bus.id_fire[k] & bus.id_dst_we[k] & ~bus.id_is_div[k];
                stage_d[0][k].dst      = bus.id_dst_reg[k*REG_W +: REG_W];
                stage_d[0][k].ready_at = SB_READY_W'(bus.id_ready_at[k*READY_W +: READY_W]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: this is a small flop array, not a RAM, so the whole entry is reset rather than just valid.
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    sb_div_tracker #(
        .NUM_ISSUE (NUM_ISSUE),
        .DIV_LAT   (DIV_LAT)
    ) u_div (
        .clk         (clk),
        .resetn      (resetn),
        .issue_i     (div_issue),
        .issue_dst_i (div_dst),
        .src_reg_i   (src),
        .src_rd_i    (src_rd),
        .is_div_i    (bus.id_is_div),
        .div_hit_o   (div_hit),
        .div_busy_o  (bus.div_busy)
    );

    assign bus.id_stall  = id_stall;
    assign bus.stall_src = stall_src;
    assign bus.lane1_dep = lane1_dep;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues hand-computed responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;
    localparam int NI = 2;
    localparam int PD = 3;
    localparam int RW = 2;
    localparam int DL = 16;

    typedef logic [11:0] resp_t;  // {id_stall[1:0], stall_src[7:0], lane1_dep, div_busy}

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    hazard_scoreboard_if #(.NUM_ISSUE(NI), .PIPE_DEPTH(PD), .READY_W(RW)) bus ();

    hazard_scoreboard #(
        .NUM_ISSUE  (NI),
        .PIPE_DEPTH (PD),
        .READY_W    (RW),
        .DIV_LAT    (DL)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    resp_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic resp_t pack(logic [1:0] st, logic [7:0] src, logic dep, logic busy);
        return {st, src, dep, busy};
    endfunction

    task automatic check(string name, resp_t act, resp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got stall=%b src=%b dep=%b busy=%b, want stall=%b src=%b dep=%b busy=%b",
                     name, act[11:10], act[9:2], act[1], act[0],
                     exp[11:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: outputs are combinational, so each queued response is sampled mid-cycle.
    initial begin
        resp_t e;
        string n;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, {bus.id_stall, bus.stall_src, bus.lane1_dep, bus.div_busy}, e);
            end
        end
    end

    task automatic clr();
        bus.id_src_reg   = '0;
        bus.id_src_rd    = '0;
        bus.id_dst_reg   = '0;
        bus.id_dst_we    = '0;
        bus.id_ready_at  = '0;
        bus.id_is_div    = '0;
        bus.id_fire      = '0;
        bus.pipe_advance = 1'b1;
        bus.flush        = 1'b0;
    endtask

    task automatic issue(int l, logic [4:0] dst, logic [1:0] rdy, logic div);
        bus.id_dst_reg[l*5 +: 5]   = dst;
        bus.id_dst_we[l]           = 1'b1;
        bus.id_ready_at[l*2 +: 2]  = rdy;
        bus.id_is_div[l]           = div;
        bus.id_fire[l]             = 1'b1;
    endtask

    task automatic rd(int l, logic [4:0] rs, logic rs_en, logic [4:0] rt, logic rt_en);
        bus.id_src_reg[l*10 +: 10] = {rs, rt};
        bus.id_src_rd[l*2 +: 2]    = {rs_en, rt_en};
    endtask

    task automatic cyc(string name, resp_t e);
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        clr();
        @(posedge clk);
        #1;

        rd(0, 5'd5, 1, 5'd5, 1);
        cyc("reset", pack(0, 0, 0, 0));
        resetn = 1'b1;

        // Load r5 walks EX -> MEM1 -> MEM2, then releases.
        issue(0, 5'd5, 2'd3, 0);  cyc("ld_issue", pack(0, 0, 0, 0));
        rd(0, 5'd5, 1, 0, 0);     cyc("ld_ex",    pack(2'b01, 8'h01, 0, 0));
        rd(0, 5'd5, 1, 0, 0);     cyc("ld_mem1",  pack(2'b01, 8'h02, 0, 0));
        rd(0, 5'd5, 1, 0, 0);     cyc("ld_mem2",  pack(2'b01, 8'h04, 0, 0));
        rd(0, 5'd5, 1, 0, 0);     cyc("ld_free",  pack(0, 0, 0, 0));

        // MFC0 r8 read by lane 1 on rt; then an ALU write to r8 never stalls.
        issue(0, 5'd8, 2'd2, 0);  cyc("mfc0_issue", pack(0, 0, 0, 0));
        rd(1, 0, 0, 5'd8, 1);     cyc("mfc0_ex",    pack(2'b10, 8'h10, 0, 0));
        rd(1, 0, 0, 5'd8, 1);     cyc("mfc0_mem1",  pack(2'b10, 8'h20, 0, 0));
        rd(1, 0, 0, 5'd8, 1);     cyc("mfc0_mem2",  pack(0, 0, 0, 0));
        issue(0, 5'd8, 2'd0, 0);  cyc("alu_issue",  pack(0, 0, 0, 0));
        rd(0, 5'd8, 1, 5'd8, 1);  cyc("alu_ex",     pack(0, 0, 0, 0));
        rd(0, 5'd8, 1, 0, 0);     cyc("alu_mem1",   pack(0, 0, 0, 0));

        // Load to r0 never causes a hazard.
        issue(0, 5'd0, 2'd3, 0);  cyc("r0_issue", pack(0, 0, 0, 0));
        rd(0, 0, 1, 0, 1);
        rd(1, 0, 1, 0, 1);        cyc("r0_ex",    pack(0, 0, 0, 0));
        rd(0, 0, 1, 0, 1);        cyc("r0_mem1",  pack(0, 0, 0, 0));

        // Intra-bundle dependency: lane 1 waits, then issues alone behind an ALU op.
        issue(0, 5'd3, 2'd0, 0);
        rd(1, 5'd3, 1, 0, 0);     cyc("bundle",       pack(2'b10, 8'h10, 1, 0));
        rd(1, 5'd3, 1, 0, 0);     cyc("bundle_alone", pack(0, 0, 0, 0));

        // Two pending loads: youngest stage wins, then an older stage alone.
        issue(0, 5'd5, 2'd3, 0);  cyc("pri_a",     pack(0, 0, 0, 0));
        issue(0, 5'd6, 2'd3, 0);  cyc("pri_b",     pack(0, 0, 0, 0));
        rd(0, 5'd5, 1, 5'd6, 1);  cyc("pri_young", pack(2'b01, 8'h01, 0, 0));
        rd(0, 5'd5, 1, 0, 0);     cyc("pri_mem2",  pack(2'b01, 8'h04, 0, 0));
        cyc("pri_drain", pack(0, 0, 0, 0));

        // Load r7 held in MEM1 while the pipe is frozen, then flushed.
        issue(0, 5'd7, 2'd3, 0);  cyc("hold_issue", pack(0, 0, 0, 0));
        rd(0, 5'd7, 1, 0, 0);     cyc("hold_ex",    pack(2'b01, 8'h01, 0, 0));
        for (int i = 0; i < 4; i++) begin
            rd(0, 5'd7, 1, 0, 0);
            bus.pipe_advance = 1'b0;
            cyc("hold_mem1", pack(2'b01, 8'h02, 0, 0));
        end
        rd(0, 5'd7, 1, 0, 0);
        bus.flush = 1'b1;
        issue(1, 5'd7, 2'd3, 0);  cyc("flush_cycle", pack(2'b01, 8'h02, 0, 0));
        rd(0, 5'd7, 1, 0, 0);     cyc("after_flush", pack(0, 0, 0, 0));

        // Divide to r9: sixteen stalled cycles, survives a flush, blocks a second divide.
        issue(0, 5'd9, 2'd0, 1);  cyc("div_issue", pack(0, 0, 0, 0));
        for (int i = 0; i < DL; i++) begin
            rd(0, 5'd9, 1, 0, 0);
            if (i == 5) bus.flush = 1'b1;
            if (i == 3) begin
                bus.id_is_div[1] = 1'b1;
                cyc("div_second", pack(2'b11, 8'h88, 0, 1));
            end else begin
                cyc("div_wait", pack(2'b01, 8'h08, 0, 1));
            end
        end
        rd(0, 5'd9, 1, 0, 0);     cyc("div_done", pack(0, 0, 0, 0));

        bus.id_is_div = 2'b11;    cyc("dual_div", pack(2'b10, 8'h80, 0, 0));

        // Asynchronous reset in the middle of a divider count.
        issue(0, 5'd9, 2'd0, 1);  cyc("div2_issue", pack(0, 0, 0, 0));
        rd(0, 5'd9, 1, 0, 0);     cyc("div2_busy",  pack(2'b01, 8'h08, 0, 1));
        rd(0, 5'd9, 1, 0, 0);
        resetn = 1'b0;            cyc("div2_reset", pack(0, 0, 0, 0));
        resetn = 1'b1;
        rd(0, 5'd9, 1, 0, 0);     cyc("div2_after", pack(0, 0, 0, 0));

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drained: got %0d unchecked responses, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
